// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential RV64 M-extension multiplier/divider (shift-add multiply, restoring divide).
// Define MULTDIV_FAST_MUL_EN to replace the iterative multiplier with a one-cycle registered multiplier.
package decode_pkg;
    typedef enum logic [3:0] {
        MULT_MUL, MULT_MULW, MULT_DIV, MULT_DIVU, MULT_REM,
        MULT_REMU, MULT_DIVW, MULT_DIVUW, MULT_REMW, MULT_REMUW
    } mult_type_t;
endpackage

module multdiv_seq
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  mult_type_t  mult_type_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic is_w(mult_type_t t);
        return t inside {MULT_MULW, MULT_DIVW, MULT_DIVUW, MULT_REMW, MULT_REMUW};
    endfunction
    function automatic logic is_s(mult_type_t t);
        return t inside {MULT_DIV, MULT_REM, MULT_DIVW, MULT_REMW};
    endfunction
    function automatic logic is_m(mult_type_t t);
        return t inside {MULT_MUL, MULT_MULW};
    endfunction
    function automatic logic is_r(mult_type_t t);
        return t inside {MULT_REM, MULT_REMU, MULT_REMW, MULT_REMUW};
    endfunction

    state_t      state_q, state_d;
    mult_type_t  op_q, op_d;
    // x: multiplicand / dividend-quotient shifter, y: multiplier / divisor, acc: product / remainder
    logic [63:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic        negq_q, negq_d, negr_q, negr_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        in_w, in_s, a_neg, b_neg, dz, ovf, div_ge;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, quo, rem, res;
    logic [64:0] div_r;

    assign in_w   = is_w(mult_type_i);
    assign in_s   = is_s(mult_type_i);
    assign a_ext  = in_w ? {{32{in_s & a_i[31]}}, a_i[31:0]} : a_i;
    assign b_ext  = in_w ? {{32{in_s & b_i[31]}}, b_i[31:0]} : b_i;
    assign a_neg  = in_s & a_ext[63];
    assign b_neg  = in_s & b_ext[63];
    assign a_mag  = a_neg ? -a_ext : a_ext;
    assign b_mag  = b_neg ? -b_ext : b_ext;
    assign dz     = b_ext == '0;
    assign ovf    = in_s & (a_ext == (in_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) & (&b_ext);
    assign div_r  = {acc_q, x_q[63]};
    assign div_ge = div_r >= {1'b0, y_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (valid_i) begin
                op_d  = mult_type_i;
                y_d   = is_m(mult_type_i) ? b_ext : b_mag;
                cnt_d = in_w ? 6'd31 : 6'd63;
                if (is_m(mult_type_i)) begin
                    x_d     = a_ext;
                    acc_d   = '0;
                    state_d = MUL;
                end else if (dz | ovf) begin
                    x_d     = dz ? '1 : a_ext;
                    acc_d   = dz ? a_ext : '0;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    x_d     = in_w ? {a_mag[31:0], 32'h0} : a_mag;
                    acc_d   = '0;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    state_d = DIV;
                end
            end
`ifdef MULTDIV_FAST_MUL_EN
            MUL: begin
                acc_d   = x_q * y_q;
                state_d = DONE;
            end
`else
            MUL: begin
                acc_d   = acc_q + (y_q[0] ? x_q : '0);
                x_d     = x_q << 1;
                y_d     = y_q >> 1;
                cnt_d   = cnt_q - 6'd1;
                state_d = cnt_q == '0 ? DONE : MUL;
            end
`endif
            DIV: begin
                acc_d   = div_ge ? div_r[63:0] - y_q : div_r[63:0];
                x_d     = {x_q[62:0], div_ge};
                cnt_d   = cnt_q - 6'd1;
                state_d = cnt_q == '0 ? DONE : DIV;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MULT_MUL;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o  = state_q == IDLE;
    assign busy_o   = state_q != IDLE;
    assign done_o   = state_q == DONE;
    assign quo      = negq_q ? -x_q : x_q;
    assign rem      = negr_q ? -acc_q : acc_q;
    assign res      = is_m(op_q) ? acc_q : is_r(op_q) ? rem : quo;
    assign result_o = done_o ? (is_w(op_q) ? {{32{res[31]}}, res[31:0]} : res) : '0;
endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 SHALL expose: clk  input  1  system clock.
REQ-003 SHALL expose: reset  input  1  synchronous active-high reset.
REQ-004 SHALL expose: valid_i  input  1  request presented by the execute stage.
REQ-005 SHALL expose: ready_o  output  1  sequencer idle and accepting.
REQ-006 SHALL expose: mult_type_i  input  decode_pkg mult_type_t  operation: MULT_MUL, MULT_MULW, MULT_DIV, MULT_DIVU, MULT_REM, MULT_REMU, MULT_DIVW, MULT_DIVUW, MULT_REMW, MULT_REMUW.
REQ-007 SHALL expose: a_i, b_i  input  64 each  rs1 and rs2 operands.
REQ-008 SHALL expose: flush_i  input  1  abort the in-flight operation.
REQ-009 SHALL expose: busy_o  output  1  operation in flight; pipeline stalls on it.
REQ-010 SHALL expose: done_o  output  1  one-cycle result strobe.
REQ-011 SHALL expose: result_o  output  64  result, valid only while done_o=1.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; ready_o=1 only in IDLE, and busy_o=1 in MUL, DIV and DONE.
REQ-013 SHALL accept a request in cycle 0 when valid_i=1 and ready_o=1, latching operands and type.
REQ-014 SHALL compute MUL as the low 64 bits of a*b and MULW as sext32((a[31:0]*b[31:0])[31:0]).
REQ-015 SHALL compute MUL/MULW iteratively, shift-add at 1 bit per cycle: 64 cycles in MUL for 64-bit operations and 32 cycles for W operations.
REQ-016 SHALL compute DIV/REM iteratively, restoring at 1 bit per cycle: 64 cycles for 64-bit operations and 32 cycles for W operations.
REQ-017 SHALL, for signed division, divide magnitudes, then negate the quotient if the operand signs differ and the remainder if the dividend is negative.
REQ-018 SHALL, for W operations, use operand bits [31:0] (sign- or zero-extended per signedness) and sign-extend the 32-bit result to 64 bits.
REQ-019 SHALL handle divide by zero: quotient all-ones, remainder = dividend (W: sext32 of the low 32 bits).
REQ-020 SHALL handle signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
REQ-021 SHALL skip DIV for the REQ-019/020 cases, going IDLE->DONE so that done_o asserts in cycle 1.
REQ-022 SHALL, for iterative operations of N iterations, assert done_o in cycle N+1 (65 for 64-bit, 33 for W), then return to IDLE.
REQ-023 SHALL hold done_o for exactly one cycle, then return to IDLE; a new request is accepted in the cycle after done_o.
REQ-024 SHALL, on flush_i=1 in any state, go to IDLE next cycle with no done_o; flush_i together with valid_i in IDLE starts nothing.
REQ-025 SHALL drive result_o to 0 when done_o=0.

Reset
REQ-026 SHALL, while reset=1, force IDLE with ready_o=1, busy_o=0, done_o=0, result_o=0, and clear all iteration counters and partial registers.
REQ-027 SHALL make reset take priority over flush_i and valid_i; reset mid-operation discards the operation with no done_o.

Configuration
REQ-028 SHALL support the macro MULTDIV_FAST_MUL_EN.
REQ-029 SHALL, with MULTDIV_FAST_MUL_EN defined, compute MUL/MULW with a single-cycle registered multiplier: state MUL lasts one cycle and done_o asserts in cycle 2.
REQ-030 SHALL, without MULTDIV_FAST_MUL_EN, use the iterative multiplier of REQ-015; division is unaffected either way.

Verification
REQ-031 SHALL cover: MUL a=3, b=0xFFFFFFFFFFFFFFFB -> result 0xFFFFFFFFFFFFFFF1, done_o in cycle 65 (cycle 2 with the macro).
REQ-032 SHALL cover: DIV a=0xFFFFFFFFFFFFFFF9 (-7), b=2 -> 0xFFFFFFFFFFFFFFFD; REM on the same operands -> 0xFFFFFFFFFFFFFFFF; each done_o in cycle 65.
REQ-033 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFFFFFFFFFF; REMU a=5, b=0 -> 5; each done_o in cycle 1.
REQ-034 SHALL cover: DIVW a=0x0000000080000000, b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000, done_o in cycle 1; REMW on the same operands -> 0.
REQ-035 SHALL cover: DIVUW a=100, b=7 started, flush_i in cycle 10 -> IDLE in cycle 11, no done_o; then REMUW a=100, b=7 -> 2 at cycle 33.
REQ-036 SHALL cover: reset asserted in cycle 20 of a DIV -> ready_o=1, done_o never asserted, next request computes correctly.
